pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Fetch-stage controller. Owns the architectural PC register and drives `pc_out` into the PC adder.
- Registers the adder's `next_pc` result when the current instruction is accepted by decode.
- Sequences a fixed-latency instruction-memory read and presents the fetched word to decode with a valid/ready handshake.
- Accepts a flush/redirect from the execute stage that overrides everything.

Parameters:
- PC_W, 12, PC and IMEM address width.
- INSN_W, 32, instruction word width.
- IMEM_LAT, 1, IMEM read latency in cycles (legal 1..4).
- RESET_PC, 12'd0, PC value loaded by reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- next_pc_in  in  PC_W  next PC from the PC adder (combinational function of pc_out).
- flush  in  1  redirect request from execute.
- flush_pc  in  PC_W  redirect target.
- decode_ready  in  1  decode can accept an instruction this cycle.
- imem_rd  out  1  IMEM read strobe, one cycle per request.
- imem_addr  out  PC_W  IMEM address.
- imem_rdata  in  INSN_W  IMEM data, valid IMEM_LAT cycles after imem_rd.
- pc_out  out  PC_W  current PC register.
- insn_out  out  INSN_W  fetched instruction.
- insn_pc  out  PC_W  PC of insn_out.
- insn_valid  out  1  insn_out/insn_pc valid.
- fetch_count  out  16  accepted-fetch counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - pc_out=RESET_PC; insn_out=0; insn_pc=0; insn_valid=0; imem_rd=0; fetch_count=0.
  - State=REQ. Wait counter=0.
- imem_addr is always equal to pc_out (combinational).
- FSM states: REQ, WAIT, VALID.
- REQ:
  - imem_rd=1 for exactly one cycle.
  - Load wait counter with IMEM_LAT-1, then go to WAIT.
- WAIT:
  - imem_rd=0.
  - If counter≠0: decrement and stay.
  - If counter==0: imem_rdata is valid this cycle. Register insn_out<=imem_rdata, insn_pc<=pc_out, insn_valid<=1, then go to VALID.
- VALID:
  - insn_valid=1; outputs stable.
  - If decode_ready=1: pc_out<=next_pc_in, insn_valid<=0, go to REQ.
  - Else stay, holding everything.
- Latency: a REQ in cycle t gives insn_valid=1 in cycle t+IMEM_LAT+1. Back-to-back fetch period with decode always ready is IMEM_LAT+2 cycles.
- Flush (any state) has priority over accept and over data capture:
  - pc_out<=flush_pc; insn_valid<=0; counter<=0; go to REQ.
  - An in-flight IMEM response is discarded and never reaches insn_out.
  - Flush in VALID with decode_ready=1 does not count as an accept.
- PC arithmetic is owned by the adder. This block registers next_pc_in verbatim, including the 12'hFFF→12'h000 wrap and jump/branch targets.
- pc_out changes only on accept, flush, or reset.
- decode_ready is ignored outside VALID.
- flush during reset is ignored.
- Reset asserted mid-fetch aborts immediately. After release, fetch restarts at RESET_PC.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined:
  - fetch_count increments by 1 on each accept (VALID & decode_ready & !flush).
  - Saturates at 16'hFFFF.
  - Cleared only by reset; flush does not clear it.
- Undefined: fetch_count is tied to 16'd0 and no counter logic is instantiated. The port exists in both builds.

Test Plan:
- Reset release, IMEM_LAT=1, decode_ready=1, next_pc_in=pc_out+1, IMEM returns addr-indexed words → imem_rd pulses at addresses 0,1,2 every 3 cycles; insn_pc sequence 0,1,2; first insn_valid 2 cycles after first imem_rd.
- IMEM_LAT=3, decode_ready=1 → first insn_valid exactly 4 cycles after imem_rd; period 5 cycles; insn_out matches word at each address.
- decode_ready=0 for 5 cycles while insn_valid=1 (insn_pc=0x004) → insn_out, insn_pc, pc_out frozen, no imem_rd; on decode_ready=1, pc_out becomes next_pc_in (0x005) next cycle.
- flush=1 with flush_pc=0x0A0 during WAIT → IMEM data discarded, insn_valid stays 0, next imem_rd at 0x0A0, next insn_pc=0x0A0.
- flush=1 in VALID with decode_ready=1, flush_pc=0x123, next_pc_in=0x010 → pc_out=0x123, not 0x010; fetch_count unchanged (FETCH_COUNT_EN).
- pc_out=0xFFF, next_pc_in=0x000 accepted → pc_out=0x000, imem_rd at 0x000. Separately, reset_n pulsed low mid-WAIT → all outputs immediately at reset values, restart at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: owns the PC, issues one fixed-latency IMEM read per instruction, holds the result for decode.
// REQ->WAIT->VALID costs IMEM_LAT+2 cycles per fetch; flush wins over everything; FETCH_COUNT_EN adds an accept counter.
module pc_fetch_ctrl #(
  parameter int              PC_W     = 12,
  parameter int              INSN_W   = 32,
  parameter int              IMEM_LAT = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   next_pc_in,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              decode_ready,
  output logic              imem_rd,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   pc_out,
  output logic [INSN_W-1:0] insn_out,
  output logic [PC_W-1:0]   insn_pc,
  output logic              insn_valid,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {REQ, WAIT, VALID} state_t;

  localparam logic [1:0] LAT_M1 = 2'(IMEM_LAT - 1);

  state_t              state_q;
  logic [1:0]          cnt_q;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     insn_pc_q;
  logic [INSN_W-1:0]   insn_q;
  logic                valid_q;
  logic                rd_q;

  // rd_q is the registered strobe; a REQ entered from reset spends one cycle arming it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= REQ;
      cnt_q     <= 2'd0;
      pc_q      <= RESET_PC;
      insn_pc_q <= '0;
      insn_q    <= '0;
      valid_q   <= 1'b0;
      rd_q      <= 1'b0;
    end else if (flush) begin
      state_q <= REQ;
      cnt_q   <= 2'd0;
      pc_q    <= flush_pc;
      valid_q <= 1'b0;
      rd_q    <= 1'b1;
    end else begin
      case (state_q)
        REQ: begin
          if (rd_q) begin
            rd_q    <= 1'b0;
            cnt_q   <= LAT_M1;
            state_q <= WAIT;
          end else begin
            rd_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            insn_q    <= imem_rdata;
            insn_pc_q <= pc_q;
            valid_q   <= 1'b1;
            state_q   <= VALID;
          end
        end
        VALID: begin
          if (decode_ready) begin
            pc_q    <= next_pc_in;
            valid_q <= 1'b0;
            rd_q    <= 1'b1;
            state_q <= REQ;
          end
        end
        default: begin
          state_q <= REQ;
          rd_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_rd    = rd_q;
  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign insn_out   = insn_q;
  assign insn_pc    = insn_pc_q;
  assign insn_valid = valid_q;

`ifdef FETCH_COUNT_EN
  logic        accept;
  logic [15:0] fcnt_q;
  logic [15:0] fcnt_d;

  assign accept = (state_q == VALID) && decode_ready && !flush;

  always_comb begin
    fcnt_d = fcnt_q;
    if (accept && (fcnt_q != 16'hFFFF)) fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fcnt_q <= 16'd0;
    else          fcnt_q <= fcnt_d;
  end

  assign fetch_count = fcnt_q;
`else
  assign fetch_count = 16'd0;
`endif

endmodule
